// File: rtl/decoder_4x16_seq.sv
// Sequenced 4-to-16 decoder: each accepted index drives a one-hot Y for HOLD_CYCLES cycles,
// then one zero cycle. Define DEC_QUEUE_EN to add a one-entry input queue.
module decoder_4x16_seq #(
    parameter int HOLD_CYCLES = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  A,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [15:0] Y,
    output logic        out_valid,
    output logic [7:0]  pulse_cnt
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        GAP   = 2'd2
    } state_t;

    localparam logic [3:0] HOLD_LOAD = 4'(HOLD_CYCLES - 1);

    state_t      state;
    state_t      state_next;
    logic [15:0] y_next;
    logic [3:0]  hold_cnt;
    logic [3:0]  hold_next;
    logic [7:0]  cnt_next;
    logic        accept;

`ifdef DEC_QUEUE_EN
    logic        q_full;
    logic        q_full_next;
    logic [3:0]  q_idx;
    logic [3:0]  q_idx_next;

    // Queue is always empty in IDLE, so this also keeps IDLE ready.
    assign in_ready = !q_full;
`else
    assign in_ready = (state == IDLE);
`endif

    assign accept    = in_valid && in_ready;
    assign out_valid = |Y;

    always_comb begin
        state_next = state;
        y_next     = Y;
        hold_next  = hold_cnt;
        cnt_next   = pulse_cnt;
`ifdef DEC_QUEUE_EN
        q_full_next = q_full;
        q_idx_next  = q_idx;
`endif
        case (state)
            IDLE: begin
                if (accept) begin
                    state_next = DRIVE;
                    y_next     = 16'h0001 << A;
                    hold_next  = HOLD_LOAD;
                end
            end
            DRIVE: begin
`ifdef DEC_QUEUE_EN
                if (accept) begin
                    q_full_next = 1'b1;
                    q_idx_next  = A;
                end
`endif
                if (hold_cnt == 4'd0) begin
                    state_next = GAP;
                    y_next     = 16'h0000;
                end else begin
                    hold_next = hold_cnt - 4'd1;
                end
            end
            GAP: begin
                // The pulse counts as complete only once its gap cycle finishes.
                cnt_next = pulse_cnt + 8'd1;
`ifdef DEC_QUEUE_EN
                if (q_full) begin
                    state_next  = DRIVE;
                    y_next      = 16'h0001 << q_idx;
                    hold_next   = HOLD_LOAD;
                    q_full_next = 1'b0;
                end else if (accept) begin
                    state_next = DRIVE;
                    y_next     = 16'h0001 << A;
                    hold_next  = HOLD_LOAD;
                end else begin
                    state_next = IDLE;
                end
`else
                state_next = IDLE;
`endif
            end
            default: begin
                state_next = IDLE;
                y_next     = 16'h0000;
                hold_next  = 4'd0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            Y         <= 16'h0000;
            hold_cnt  <= 4'd0;
            pulse_cnt <= 8'd0;
`ifdef DEC_QUEUE_EN
            q_full    <= 1'b0;
            q_idx     <= 4'd0;
`endif
        end else begin
            state     <= state_next;
            Y         <= y_next;
            hold_cnt  <= hold_next;
            pulse_cnt <= cnt_next;
`ifdef DEC_QUEUE_EN
            q_full    <= q_full_next;
            q_idx     <= q_idx_next;
`endif
        end
    end

endmodule

// File: tb/tb_decoder_4x16_seq.sv
// Directed bench for decoder_4x16_seq (HOLD_CYCLES=4): reset, exhaustive decode,
// backpressure or queue hand-off, counter wrap and mid-pulse reset.
module tb_decoder_4x16_seq;

    logic        clk;
    logic        rst;
    logic [3:0]  A;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] Y;
    logic        out_valid;
    logic [7:0]  pulse_cnt;

    int errors;
    int checks;

`ifdef DEC_QUEUE_EN
    localparam logic DRIVE_READY = 1'b1;
`else
    localparam logic DRIVE_READY = 1'b0;
`endif

    decoder_4x16_seq #(.HOLD_CYCLES(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .A         (A),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .Y         (Y),
        .out_valid (out_valid),
        .pulse_cnt (pulse_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive inputs for the coming edge, then sample 1 time unit after it.
    task automatic applyStimulus(input logic [3:0] a, input logic v);
        A        = a;
        in_valid = v;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [15:0] actual, input logic [15:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, actual, expected);
        end
    endtask

    initial begin
        logic [15:0] exp_y;
        errors   = 0;
        checks   = 0;
        rst      = 1'b1;
        A        = 4'd0;
        in_valid = 1'b0;

        // Reset / idle
        applyStimulus(4'd0, 1'b0);
        applyStimulus(4'd0, 1'b0);
        rst = 1'b0;
        checkOutput("reset_y", Y, 16'h0000);
        checkOutput("reset_out_valid", {15'd0, out_valid}, 16'd0);
        checkOutput("reset_pulse_cnt", {8'd0, pulse_cnt}, 16'd0);
        checkOutput("reset_in_ready", {15'd0, in_ready}, 16'd1);

        // Exhaustive decode
        for (int a = 0; a < 16; a++) begin
            exp_y = 16'h0001 << a;
            applyStimulus(4'(a), 1'b1);
            checkOutput("dec_y_c1", Y, exp_y);
            checkOutput("dec_out_valid", {15'd0, out_valid}, 16'd1);
            checkOutput("dec_in_ready", {15'd0, in_ready}, {15'd0, DRIVE_READY});
            for (int k = 0; k < 3; k++) begin
                applyStimulus(4'd0, 1'b0);
                checkOutput("dec_y_hold", Y, exp_y);
            end
            applyStimulus(4'd0, 1'b0);
            checkOutput("dec_gap_y", Y, 16'h0000);
            checkOutput("dec_gap_out_valid", {15'd0, out_valid}, 16'd0);
            applyStimulus(4'd0, 1'b0);
            checkOutput("dec_pulse_cnt", {8'd0, pulse_cnt}, 16'(a + 1));
            checkOutput("dec_idle_ready", {15'd0, in_ready}, 16'd1);
        end
        checkOutput("dec_final_cnt", {8'd0, pulse_cnt}, 16'd16);

`ifdef DEC_QUEUE_EN
        // Queue hand-off: 5 accepted in IDLE, 12 queued during DRIVE
        applyStimulus(4'd5, 1'b1);
        checkOutput("q_y_c1", Y, 16'h0020);
        checkOutput("q_ready_c1", {15'd0, in_ready}, 16'd1);
        applyStimulus(4'd12, 1'b1);
        checkOutput("q_y_c2", Y, 16'h0020);
        checkOutput("q_ready_full", {15'd0, in_ready}, 16'd0);
        applyStimulus(4'd0, 1'b0);
        applyStimulus(4'd0, 1'b0);
        checkOutput("q_y_c4", Y, 16'h0020);
        applyStimulus(4'd0, 1'b0);
        checkOutput("q_gap_y", Y, 16'h0000);
        checkOutput("q_gap_ready", {15'd0, in_ready}, 16'd0);
        applyStimulus(4'd0, 1'b0);
        checkOutput("q_second_y", Y, 16'h1000);
        checkOutput("q_second_ready", {15'd0, in_ready}, 16'd1);
        checkOutput("q_cnt_mid", {8'd0, pulse_cnt}, 16'd17);
`else
        // Backpressure: in_valid held high, A=3 then A=9
        applyStimulus(4'd3, 1'b1);
        checkOutput("bp_y_c1", Y, 16'h0008);
        checkOutput("bp_ready_c1", {15'd0, in_ready}, 16'd0);
        for (int k = 0; k < 3; k++) begin
            applyStimulus(4'd9, 1'b1);
            checkOutput("bp_y_hold", Y, 16'h0008);
            checkOutput("bp_ready_drive", {15'd0, in_ready}, 16'd0);
        end
        applyStimulus(4'd9, 1'b1);
        checkOutput("bp_gap_y", Y, 16'h0000);
        checkOutput("bp_gap_ready", {15'd0, in_ready}, 16'd0);
        applyStimulus(4'd9, 1'b1);
        checkOutput("bp_idle_y", Y, 16'h0000);
        checkOutput("bp_idle_ready", {15'd0, in_ready}, 16'd1);
        applyStimulus(4'd9, 1'b1);
        checkOutput("bp_second_y", Y, 16'h0200);
`endif
        for (int k = 0; k < 3; k++) applyStimulus(4'd0, 1'b0);
        checkOutput("second_y_c4", Y, (16'h0001 << (DRIVE_READY ? 12 : 9)));
        applyStimulus(4'd0, 1'b0);
        applyStimulus(4'd0, 1'b0);
        checkOutput("second_cnt", {8'd0, pulse_cnt}, 16'd18);

        // Wrap: fresh reset, then 256 pulses of A=0
        rst = 1'b1;
        applyStimulus(4'd0, 1'b0);
        rst = 1'b0;
        checkOutput("wrap_start_cnt", {8'd0, pulse_cnt}, 16'd0);
        for (int p = 1; p <= 256; p++) begin
            applyStimulus(4'd0, 1'b1);
            for (int k = 0; k < 4; k++) applyStimulus(4'd0, 1'b0);
            applyStimulus(4'd0, 1'b0);
            if (p == 1)   checkOutput("wrap_cnt_1", {8'd0, pulse_cnt}, 16'd1);
            if (p == 255) checkOutput("wrap_cnt_255", {8'd0, pulse_cnt}, 16'd255);
            if (p == 256) checkOutput("wrap_cnt_256", {8'd0, pulse_cnt}, 16'd0);
        end

        // Mid-pulse reset: A=15, something offered in DRIVE, reset on 2nd DRIVE cycle
        applyStimulus(4'd15, 1'b1);
        checkOutput("mr_y_c1", Y, 16'h8000);
        applyStimulus(4'd7, 1'b1);
        checkOutput("mr_y_c2", Y, 16'h8000);
        rst = 1'b1;
        applyStimulus(4'd7, 1'b1);
        rst = 1'b0;
        checkOutput("mr_y_after", Y, 16'h0000);
        checkOutput("mr_out_valid", {15'd0, out_valid}, 16'd0);
        checkOutput("mr_pulse_cnt", {8'd0, pulse_cnt}, 16'd0);
        checkOutput("mr_ready", {15'd0, in_ready}, 16'd1);
        for (int k = 0; k < 6; k++) begin
            applyStimulus(4'd0, 1'b0);
            checkOutput("mr_queue_lost", Y, 16'h0000);
        end
        checkOutput("mr_cnt_final", {8'd0, pulse_cnt}, 16'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/decoder_4x16_seq.md
DECODER_4X16_SEQ -- requirements
Module: decoder_4x16_seq

Interface
REQ-001 SHALL have parameter HOLD_CYCLES, default 4, giving the number of cycles each one-hot output is held (legal range 1..15).
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-004 SHALL have port A, input, 4 bits: encoded index to decode.
REQ-005 SHALL have port in_valid, input, 1 bit: A is valid this cycle.
REQ-006 SHALL have port in_ready, output, 1 bit: the block accepts A this cycle.
REQ-007 SHALL have port Y, output, 16 bits: one-hot decoded output, or all zero.
REQ-008 SHALL have port out_valid, output, 1 bit: high exactly when Y is non-zero.
REQ-009 SHALL have port pulse_cnt, output, 8 bits: count of completed output pulses.

Function
REQ-010 SHALL accept a transfer on any rising edge where in_valid=1 and in_ready=1; with in_ready=0, A and in_valid are ignored.
REQ-011 SHALL implement the states IDLE, DRIVE and GAP, all registered.
REQ-012 In IDLE: in_ready=1 and Y=0; an accept moves the block to DRIVE, loads Y=16'h0001<<A and loads the hold counter with HOLD_CYCLES-1.
REQ-013 In DRIVE: Y holds its value; the hold counter decrements each cycle; DRIVE exits to GAP on the edge where the counter equals 0.
REQ-014 Y SHALL therefore be non-zero for exactly HOLD_CYCLES consecutive cycles per accepted index, starting the cycle after the accept (latency 1).
REQ-015 In GAP: Y=0 for exactly one cycle and pulse_cnt increments by 1; GAP then goes to IDLE, unless REQ-024 applies.
REQ-016 pulse_cnt SHALL wrap from 255 to 0 with no flag or stall.
REQ-017 Without DEC_QUEUE_EN, in_ready SHALL be 0 in DRIVE and GAP, so back-to-back accepts are spaced HOLD_CYCLES+2 cycles apart.
REQ-018 Y SHALL never have more than one bit set; out_valid SHALL equal the OR-reduction of Y.
REQ-019 in_ready SHALL depend only on registered state (no combinational path from in_valid or A).
REQ-020 With HOLD_CYCLES=1, DRIVE SHALL last exactly one cycle.

Reset
REQ-021 While rst=1 at a rising edge, the next state SHALL be: state IDLE, Y=0, out_valid=0, hold counter=0, pulse_cnt=0, queue empty, and in_ready=1 once rst deasserts.
REQ-022 A reset asserted mid-DRIVE or mid-GAP SHALL abort the pulse without incrementing pulse_cnt and discard any queued index; rst has priority over every accept.

Configuration
REQ-023 Macro DEC_QUEUE_EN, when defined, SHALL add a one-entry input queue; when undefined, the block SHALL behave exactly as REQ-017 describes, with no queue logic.
REQ-024 With DEC_QUEUE_EN defined:
- in_ready = !queue_full in every state.
- An accept in IDLE bypasses the queue; an accept in DRIVE or GAP fills the queue.
- On leaving GAP with the queue full, the block SHALL go directly to DRIVE with the queued index and empty the queue; the GAP cycle between pulses is still always present.
REQ-025 With DEC_QUEUE_EN defined, an accept in GAP while the queue is empty SHALL be written to the queue and launched on that same GAP exit edge, with no IDLE cycle.

Verification
REQ-026 Reset/idle: hold rst=1 for 2 cycles, then release -> Y=0, out_valid=0, pulse_cnt=0, in_ready=1.
REQ-027 Exhaustive decode (HOLD_CYCLES=4): apply A=0..15 one at a time -> Y=16'h0001<<A for 4 cycles, then 1 zero cycle; pulse_cnt=16 at the end.
REQ-028 Backpressure (no queue): hold in_valid=1 with A=3 then A=9 -> Y=16'h0008 for 4 cycles, 1 gap cycle, 1 IDLE cycle, then Y=16'h0200; in_ready=0 throughout DRIVE and GAP.
REQ-029 Queue (DEC_QUEUE_EN): accept A=5 in IDLE, then A=12 in DRIVE -> Y=16'h0020 for 4 cycles, exactly 1 zero cycle, then Y=16'h1000; in_ready=0 only while the queue is full.
REQ-030 Wrap: complete 256 pulses of A=0 -> pulse_cnt reads 255 after pulse 255 and 0 after pulse 256.
REQ-031 Mid-pulse reset: accept A=15, assert rst at the 2nd DRIVE cycle -> Y=0 the next cycle, pulse_cnt unchanged at 0, queued entry lost.
